// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared kinds, opcodes, funct codes and FSM states for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

   typedef enum logic [2:0] {
      KIND_RTYPE = 3'd0,
      KIND_ADDI  = 3'd1,
      KIND_LW    = 3'd2,
      KIND_SW    = 3'd3,
      KIND_J     = 3'd4,
      KIND_BEQ   = 3'd5,
      KIND_IMM12 = 3'd6,
      KIND_IMM48 = 3'd7
   } kind_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_imm12 = 6'b001100;
   localparam logic [5:0] c_op_imm48 = 6'b110000;

   localparam logic [5:0] c_funct_add = 6'd32;
   localparam logic [5:0] c_funct_sub = 6'd34;
   localparam logic [5:0] c_funct_and = 6'd36;
   localparam logic [5:0] c_funct_or  = 6'd37;
   localparam logic [5:0] c_funct_slt = 6'd42;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // R-type functions the core's ALU decoder actually implements
   function automatic logic funct_legal(input logic [5:0] funct);
      return (funct == c_funct_add) || (funct == c_funct_sub) ||
             (funct == c_funct_and) || (funct == c_funct_or)  ||
             (funct == c_funct_slt);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Request handshake and instruction-memory write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   kind_t             in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [5:0]        in_funct;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader_instr_pack.sv
// ============================================================================
// Module   : instr_pack
// Purpose  : Combinational packer from decoded request fields to a MIPS word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
   import imem_loader_pkg::*;
(
   input  kind_t       kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word
);
   logic [5:0] w_op;

   always_comb begin
      w_op = c_op_rtype;
      case (kind)
         KIND_RTYPE: w_op = c_op_rtype;
         KIND_ADDI:  w_op = c_op_addi;
         KIND_LW:    w_op = c_op_lw;
         KIND_SW:    w_op = c_op_sw;
         KIND_J:     w_op = c_op_j;
         KIND_BEQ:   w_op = c_op_beq;
         KIND_IMM12: w_op = c_op_imm12;
         KIND_IMM48: w_op = c_op_imm48;
         default:    w_op = c_op_rtype;
      endcase

      word = {w_op, rs, rt, imm};
      if (kind == KIND_RTYPE) begin
         word = {w_op, rs, rt, rd, 5'b0, funct};
      end else if (kind == KIND_J) begin
         word = {w_op, target};
      end
   end
endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Session FSM that packs requests and writes them to sequential
//            instruction-memory words. IMEM_LOADER_CHECK_EN drops illegal
//            R-type functs and raises the sticky illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            finish,
   imem_loader_if.slave    bus,
   output logic            busy,
   output logic            done,
   output logic [ADDR_W:0] count,
   output logic            overflow,
   output logic            illegal
);
   localparam logic [ADDR_W:0]   c_capacity = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] c_start    = ADDR_W'(START_ADDR);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W:0]   r_count;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_overflow;
   logic              w_full;
   logic              w_ready;
   logic              w_accept;
   logic              w_legal;
   logic [31:0]       w_word;

   instr_pack u_pack (
      .kind   (bus.in_kind),
      .rs     (bus.in_rs),
      .rt     (bus.in_rt),
      .rd     (bus.in_rd),
      .funct  (bus.in_funct),
      .imm    (bus.in_imm),
      .target (bus.in_target),
      .word   (w_word)
   );

   assign w_full   = (r_count == c_capacity);
   assign w_accept = bus.in_valid && w_ready;

`ifdef IMEM_LOADER_CHECK_EN
   logic r_illegal;
   assign w_legal = (bus.in_kind != KIND_RTYPE) || funct_legal(bus.in_funct);
   assign illegal = r_illegal;
`else
   assign w_legal = 1'b1;
   assign illegal = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         ST_IDLE: if (start) w_state_next = ST_LOAD;
         ST_LOAD: begin
            // start takes priority so a restart never accepts a word
            w_ready = !w_full && !start;
            if (start)       w_state_next = ST_LOAD;
            else if (finish) w_state_next = ST_DONE;
         end
         ST_DONE: if (start) w_state_next = ST_LOAD;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECK_EN
         r_illegal  <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;
         if (start) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECK_EN
            r_illegal  <= 1'b0;
`endif
         end else if (r_state == ST_LOAD) begin
            if (w_accept && w_legal) begin
               r_we    <= 1'b1;
               r_addr  <= c_start + r_count[ADDR_W-1:0];
               r_wdata <= w_word;
               r_count <= r_count + 1'b1;
            end
`ifdef IMEM_LOADER_CHECK_EN
            if (w_accept && !w_legal) r_illegal <= 1'b1;
`endif
            if (w_full && bus.in_valid) r_overflow <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign busy           = (r_state == ST_LOAD);
   assign done           = (r_state == ST_DONE);
   assign count          = r_count;
   assign overflow       = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed bench driving a 256-word and a 4-word loader in lockstep
//            against a behavioural model, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic        valid = 1'b0;
   logic [2:0]  kind = 3'd0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [5:0]  funct = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(8)) bus_a ();
   imem_loader_if #(.ADDR_W(2)) bus_b ();

   assign bus_a.in_valid  = valid;       assign bus_b.in_valid  = valid;
   assign bus_a.in_kind   = kind_t'(kind); assign bus_b.in_kind = kind_t'(kind);
   assign bus_a.in_rs     = rs;          assign bus_b.in_rs     = rs;
   assign bus_a.in_rt     = rt;          assign bus_b.in_rt     = rt;
   assign bus_a.in_rd     = rd;          assign bus_b.in_rd     = rd;
   assign bus_a.in_funct  = funct;       assign bus_b.in_funct  = funct;
   assign bus_a.in_imm    = imm;         assign bus_b.in_imm    = imm;
   assign bus_a.in_target = target;      assign bus_b.in_target = target;

   logic       busy_a, done_a, ovf_a, ill_a;
   logic [8:0] count_a;
   logic       busy_b, done_b, ovf_b, ill_b;
   logic [2:0] count_b;

   imem_loader #(.ADDR_W(8), .START_ADDR(0)) dut_a (
      .clk(clk), .reset(reset), .start(start), .finish(finish), .bus(bus_a),
      .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a), .illegal(ill_a)
   );

   imem_loader #(.ADDR_W(2), .START_ADDR(0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .finish(finish), .bus(bus_b),
      .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b), .illegal(ill_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] encode(input int k, input int s, input int t, input int d,
                                          input int f, input int im, input int tg);
      int op;
      case (k)
         0: op = 0;  1: op = 8;  2: op = 35; 3: op = 43;
         4: op = 2;  5: op = 4;  6: op = 12; default: op = 48;
      endcase
      if (k == 0)      return 32'(op * 67108864 + s * 2097152 + t * 65536 + d * 2048 + f);
      else if (k == 4) return 32'(op * 67108864 + tg);
      else             return 32'(op * 67108864 + s * 2097152 + t * 65536 + im);
   endfunction

   function automatic bit legal(input int k, input int f);
`ifdef IMEM_LOADER_CHECK_EN
      return (k != 0) || (f == 32) || (f == 34) || (f == 36) || (f == 37) || (f == 42);
`else
      return 1'b1;
`endif
   endfunction

   // Model: session 0=idle 1=load 2=done; outputs describe the current cycle
   int          cap[2] = '{256, 4};
   int          m_state[2], m_count[2], m_we[2], m_addr[2], m_ovf[2], m_ill[2];
   logic [31:0] m_data[2];
   bit          m_valid = 1'b0;

   task automatic compare(input int d, input logic rdy, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic bsy, input logic dn,
                          input logic [31:0] cnt, input logic ov, input logic il);
      string p;
      p = (d == 0) ? "A" : "B";
      check({p, ".in_ready"}, 32'(rdy), 32'((m_state[d] == 1) && (m_count[d] < cap[d]) && !start));
      check({p, ".imem_we"},  32'(we),  32'(m_we[d]));
      if (m_we[d] != 0) begin
         check({p, ".imem_addr"},  addr, 32'(m_addr[d]));
         check({p, ".imem_wdata"}, data, m_data[d]);
      end
      check({p, ".busy"},     32'(bsy), 32'(m_state[d] == 1));
      check({p, ".done"},     32'(dn),  32'(m_state[d] == 2));
      check({p, ".count"},    cnt,      32'(m_count[d]));
      check({p, ".overflow"}, 32'(ov),  32'(m_ovf[d]));
      check({p, ".illegal"},  32'(il),  32'(m_ill[d]));
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         compare(0, bus_a.in_ready, bus_a.imem_we, 32'(bus_a.imem_addr), bus_a.imem_wdata,
                 busy_a, done_a, 32'(count_a), ovf_a, ill_a);
         compare(1, bus_b.in_ready, bus_b.imem_we, 32'(bus_b.imem_addr), bus_b.imem_wdata,
                 busy_b, done_b, 32'(count_b), ovf_b, ill_b);
      end
      for (int d = 0; d < 2; d++) begin
         bit rdy;
         rdy = (m_state[d] == 1) && (m_count[d] < cap[d]) && !start;
         if (reset) begin
            m_state[d] = 0; m_count[d] = 0; m_we[d] = 0; m_addr[d] = 0;
            m_data[d] = '0; m_ovf[d] = 0; m_ill[d] = 0;
         end else begin
            m_we[d] = 0;
            if (start) begin
               m_state[d] = 1; m_count[d] = 0; m_ovf[d] = 0; m_ill[d] = 0;
            end else if (m_state[d] == 1) begin
               if (valid && m_count[d] == cap[d]) m_ovf[d] = 1;
               if (valid && rdy) begin
                  if (legal(int'(kind), int'(funct))) begin
                     m_we[d]   = 1;
                     m_addr[d] = m_count[d] % cap[d];
                     m_data[d] = encode(int'(kind), int'(rs), int'(rt), int'(rd),
                                        int'(funct), int'(imm), int'(target));
                     m_count[d]++;
                  end else begin
                     m_ill[d] = 1;
                  end
               end
               if (finish) m_state[d] = 2;
            end
         end
      end
      if (reset) m_valid = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                       input logic [25:0] tg);
      kind = k; rs = s; rt = t; rd = d; funct = f; imm = im; target = tg;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [2:0]  mk[5];
      logic [15:0] mi[5];
      logic [25:0] mt[5];
      logic [31:0] mw[5];
      mk = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd4};
      mi = '{16'h0000, 16'h0004, 16'h0004, 16'hFFFE, 16'h0000};
      mt = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h10};
      mw = '{32'h01095020, 32'h8D090004, 32'hAD090004, 32'h1109FFFE, 32'h08000010};

      tick(); tick();
      check("reset.in_ready",   32'(bus_a.in_ready), 32'd0);
      check("reset.imem_we",    32'(bus_a.imem_we),  32'd0);
      check("reset.imem_addr",  32'(bus_a.imem_addr), 32'd0);
      check("reset.imem_wdata", bus_a.imem_wdata,    32'd0);
      check("reset.count",      32'(count_a),        32'd0);
      reset = 1'b0;
      tick();

      // Basic ADDI session
      start = 1'b1; tick(); start = 1'b0;
      check("addi.busy", 32'(busy_a), 32'd1);
      send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
      check("addi.we",    32'(bus_a.imem_we),   32'd1);
      check("addi.addr",  32'(bus_a.imem_addr), 32'd0);
      check("addi.wdata", bus_a.imem_wdata,     32'h20080005);
      check("addi.count", 32'(count_a),         32'd1);
      finish = 1'b1; tick(); finish = 1'b0;
      check("addi.done",  32'(done_a),  32'd1);
      check("addi.count_after", 32'(count_a), 32'd1);

      // Mixed program back-to-back; the 4-word loader overflows on the fifth
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(mk[i], 5'd8, 5'd9, 5'd10, 6'd32, mi[i], mt[i]);
         check($sformatf("mix%0d.we", i),    32'(bus_a.imem_we),   32'd1);
         check($sformatf("mix%0d.addr", i),  32'(bus_a.imem_addr), 32'(i));
         check($sformatf("mix%0d.wdata", i), bus_a.imem_wdata,     mw[i]);
         if (i < 4) check($sformatf("ovf%0d.addr", i), 32'(bus_b.imem_addr), 32'(i));
      end
      check("ovf.count",    32'(count_b),        32'd4);
      check("ovf.flag",     32'(ovf_b),          32'd1);
      check("ovf.in_ready", 32'(bus_b.in_ready), 32'd0);
      check("ovf.no_write", 32'(bus_b.imem_we),  32'd0);
      check("ovf.a_clear",  32'(ovf_a),          32'd0);
      tick();
      check("ovf.ready_stays", 32'(bus_b.in_ready), 32'd0);

      // finish together with a handshake
      finish = 1'b1;
      send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd7, 26'd0);
      finish = 1'b0;
      check("fin.we",    32'(bus_a.imem_we),  32'd1);
      check("fin.wdata", bus_a.imem_wdata,    32'h20220007);
      check("fin.done",  32'(done_a),         32'd1);
      check("fin.count", 32'(count_a),        32'd6);

      // start during LOAD with a request offered
      start = 1'b1; tick(); start = 1'b0;
      send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
      start = 1'b1; valid = 1'b1; tick(); start = 1'b0; valid = 1'b0;
      check("restart.count", 32'(count_a),       32'd0);
      check("restart.we",    32'(bus_a.imem_we), 32'd0);
      check("restart.busy",  32'(busy_a),        32'd1);

      // reset the cycle after a handshake
      send(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'd8, 26'd0);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst.we",    32'(bus_a.imem_we), 32'd0);
      check("rst.busy",  32'(busy_a),        32'd0);
      check("rst.done",  32'(done_a),        32'd0);
      check("rst.count", 32'(count_a),       32'd0);

      // R-type with an unsupported funct
      start = 1'b1; tick(); start = 1'b0;
      send(3'd0, 5'd8, 5'd9, 5'd10, 6'h3F, 16'd0, 26'd0);
`ifdef IMEM_LOADER_CHECK_EN
      check("bad.we",      32'(bus_a.imem_we), 32'd0);
      check("bad.illegal", 32'(ill_a),         32'd1);
      check("bad.count",   32'(count_a),       32'd0);
`else
      check("bad.we",      32'(bus_a.imem_we), 32'd1);
      check("bad.wdata",   bus_a.imem_wdata,   32'h0109503F);
      check("bad.illegal", 32'(ill_a),         32'd0);
`endif
      finish = 1'b1; tick(); finish = 1'b0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
